// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, access-size encodings and
// the memory-mapped timer register addresses used when MMIO_TIMER_EN is defined.
package enums;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_WAIT = 2'd1,
    RESP     = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    UNIT_BYTE    = 2'b00,
    UNIT_HALF    = 2'b01,
    UNIT_WORD    = 2'b10,
    UNIT_ILLEGAL = 2'b11
  } lsu_unit_t;

  typedef enum logic [2:0] {
    MMIO_NONE        = 3'd0,
    MMIO_MCYCLE_LO   = 3'd1,
    MMIO_MCYCLE_HI   = 3'd2,
    MMIO_MTIMECMP_LO = 3'd3,
    MMIO_MTIMECMP_HI = 3'd4
  } mmio_sel_t;

  localparam logic [31:0] MMIO_MCYCLE_LO_ADDR   = 32'h0200_BFF8;
  localparam logic [31:0] MMIO_MCYCLE_HI_ADDR   = 32'h0200_BFFC;
  localparam logic [31:0] MMIO_MTIMECMP_LO_ADDR = 32'h0200_4000;
  localparam logic [31:0] MMIO_MTIMECMP_HI_ADDR = 32'h0200_4004;

  // Decode on the word address so sub-word accesses to a timer word still hit
  // (and can be rejected as access faults).
  function automatic mmio_sel_t mmio_decode(input logic [31:0] addr);
    mmio_sel_t sel;
    sel = MMIO_NONE;
    if (addr[31:2] == MMIO_MCYCLE_LO_ADDR[31:2])   sel = MMIO_MCYCLE_LO;
    if (addr[31:2] == MMIO_MCYCLE_HI_ADDR[31:2])   sel = MMIO_MCYCLE_HI;
    if (addr[31:2] == MMIO_MTIMECMP_LO_ADDR[31:2]) sel = MMIO_MTIMECMP_LO;
    if (addr[31:2] == MMIO_MTIMECMP_HI_ADDR[31:2]) sel = MMIO_MTIMECMP_HI;
    return sel;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wd;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rd;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wd, bus_be,
    input  bus_ack, bus_rd
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wd, bus_be,
    output bus_ack, bus_rd
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, store-data shift, load-data shift
// back to lane 0 (zero-filled), and the alignment check for the access size.
module lsu_lane_align
  import enums::*;
(
  input  logic [1:0]  offset,
  input  lsu_unit_t   unit,
  input  logic [31:0] wd,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wd_lane,
  output logic [31:0] rd_lane,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    case (unit)
      UNIT_BYTE: be = 4'b0001 << offset;
      UNIT_HALF: begin
        be         = 4'b0011 << offset;
        misaligned = offset[0];
      end
      UNIT_WORD: begin
        be         = 4'b1111;
        misaligned = |offset;
      end
      default: misaligned = 1'b1;
    endcase
    wd_lane = wd << {offset, 3'b000};
    rd_lane = rd_word >> {offset, 3'b000};
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with bus timeout; define MMIO_TIMER_EN to
// map the mcycle/mtimecmp timer registers into the address space.
module load_store_unit
  import enums::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wd,
  input  logic [1:0]         req_unit,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [31:0]        resp_rd,
  output logic               resp_misaligned,
  output logic               resp_access_fault,
  load_store_unit_if.master  bus,
  input  logic [63:0]        mcycle,
  input  logic [63:0]        mtimecmp,
  output logic [63:0]        mcycle_next_mem,
  output logic               mcycle_we,
  output logic [63:0]        mtimecmp_next
);

  lsu_state_t  state_reg, state_next;
  logic [31:0] addr_reg, wd_reg, rd_reg, wait_cnt_reg;
  lsu_unit_t   unit_reg;
  logic        we_reg, misaligned_reg, access_fault_reg;

  logic        accept, timeout, req_is_word, mmio_hit, mmio_ok;
  logic [31:0] mmio_rd;

  logic [1:0]  lane_offset;
  lsu_unit_t   lane_unit;
  logic [31:0] lane_wd_in, lane_wd, lane_rd;
  logic [3:0]  lane_be;
  logic        lane_misaligned;

  assign accept      = req_valid && (state_reg == IDLE);
  assign timeout     = (wait_cnt_reg == 32'(BUS_TIMEOUT - 1));
  assign req_is_word = (lsu_unit_t'(req_unit) == UNIT_WORD);
  assign mmio_ok     = mmio_hit && !lane_misaligned && req_is_word;

  // The aligner sees the incoming request while idle (for the misalign check)
  // and the latched access afterwards, which keeps bus outputs stable.
  always_comb begin
    if (state_reg == IDLE) begin
      lane_offset = req_addr[1:0];
      lane_unit   = lsu_unit_t'(req_unit);
      lane_wd_in  = req_wd;
    end else begin
      lane_offset = addr_reg[1:0];
      lane_unit   = unit_reg;
      lane_wd_in  = wd_reg;
    end
  end

  lsu_lane_align u_lane_align (
    .offset     (lane_offset),
    .unit       (lane_unit),
    .wd         (lane_wd_in),
    .rd_word    (bus.bus_rd),
    .be         (lane_be),
    .wd_lane    (lane_wd),
    .rd_lane    (lane_rd),
    .misaligned (lane_misaligned)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (lane_misaligned || mmio_hit) ? RESP : BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        if (bus.bus_ack || timeout) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      addr_reg         <= '0;
      wd_reg           <= '0;
      unit_reg         <= UNIT_BYTE;
      we_reg           <= 1'b0;
      rd_reg           <= '0;
      wait_cnt_reg     <= '0;
      misaligned_reg   <= 1'b0;
      access_fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg         <= req_addr;
            wd_reg           <= req_wd;
            unit_reg         <= lsu_unit_t'(req_unit);
            we_reg           <= req_we;
            wait_cnt_reg     <= '0;
            misaligned_reg   <= lane_misaligned;
            access_fault_reg <= mmio_hit && !lane_misaligned && !req_is_word;
            rd_reg           <= (mmio_ok && !req_we) ? mmio_rd : '0;
          end
        end
        BUS_WAIT: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (bus.bus_ack) begin
            rd_reg <= lane_rd;
          end else if (timeout) begin
            access_fault_reg <= 1'b1;
            rd_reg           <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready         = (state_reg == IDLE);
  assign resp_valid        = (state_reg == RESP);
  assign resp_rd           = resp_valid ? rd_reg : '0;
  assign resp_misaligned   = resp_valid && misaligned_reg;
  assign resp_access_fault = resp_valid && access_fault_reg;

  assign bus.bus_req  = (state_reg == BUS_WAIT);
  assign bus.bus_we   = we_reg;
  assign bus.bus_addr = {addr_reg[31:2], 2'b00};
  assign bus.bus_be   = lane_be;
  assign bus.bus_wd   = lane_wd;

`ifdef MMIO_TIMER_EN
  mmio_sel_t mmio_req_sel, mmio_sel_reg;

  assign mmio_req_sel = mmio_decode(req_addr);
  assign mmio_hit     = (mmio_req_sel != MMIO_NONE);

  always_comb begin
    mmio_rd = '0;
    case (mmio_req_sel)
      MMIO_MCYCLE_LO:   mmio_rd = mcycle[31:0];
      MMIO_MCYCLE_HI:   mmio_rd = mcycle[63:32];
      MMIO_MTIMECMP_LO: mmio_rd = mtimecmp[31:0];
      MMIO_MTIMECMP_HI: mmio_rd = mtimecmp[63:32];
      default:          mmio_rd = '0;
    endcase
  end

  // Only a legal word access keeps its register selection for the write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_sel_reg <= MMIO_NONE;
    end else if (accept) begin
      mmio_sel_reg <= mmio_ok ? mmio_req_sel : MMIO_NONE;
    end
  end

  always_comb begin
    mcycle_next_mem = mcycle;
    mcycle_we       = 1'b0;
    mtimecmp_next   = mtimecmp;
    if ((state_reg == RESP) && we_reg) begin
      case (mmio_sel_reg)
        MMIO_MCYCLE_LO: begin
          mcycle_next_mem = {mcycle[63:32], wd_reg};
          mcycle_we       = 1'b1;
        end
        MMIO_MCYCLE_HI: begin
          mcycle_next_mem = {wd_reg, mcycle[31:0]};
          mcycle_we       = 1'b1;
        end
        MMIO_MTIMECMP_LO: mtimecmp_next = {mtimecmp[63:32], wd_reg};
        MMIO_MTIMECMP_HI: mtimecmp_next = {wd_reg, mtimecmp[31:0]};
        default: ;
      endcase
    end
  end
`else
  assign mmio_hit        = 1'b0;
  assign mmio_rd         = '0;
  assign mcycle_next_mem = mcycle;
  assign mcycle_we       = 1'b0;
  assign mtimecmp_next   = mtimecmp;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (BUS_TIMEOUT=4): expected responses are
// queued when a request is issued and compared when resp_valid appears.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid, req_we, req_ready;
  logic [31:0] req_addr, req_wd;
  logic [1:0]  req_unit;
  logic        resp_valid, resp_misaligned, resp_access_fault;
  logic [31:0] resp_rd;
  logic [63:0] mcycle, mtimecmp, mcycle_next_mem, mtimecmp_next;
  logic        mcycle_we;

  load_store_unit_if bus_if ();

  load_store_unit #(.BUS_TIMEOUT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wd            (req_wd),
    .req_unit          (req_unit),
    .req_ready         (req_ready),
    .resp_valid        (resp_valid),
    .resp_rd           (resp_rd),
    .resp_misaligned   (resp_misaligned),
    .resp_access_fault (resp_access_fault),
    .bus               (bus_if.master),
    .mcycle            (mcycle),
    .mtimecmp          (mtimecmp),
    .mcycle_next_mem   (mcycle_next_mem),
    .mcycle_we         (mcycle_we),
    .mtimecmp_next     (mtimecmp_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        fault;
    int          resp_n;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [63:0] seen_mtcmp_next, seen_mcycle_next;
  logic        seen_mcycle_we;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ack_delay: BUS_WAIT cycles without ack before ack is raised (-1 = never).
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [1:0] unit,
                     input int ack_delay, input logic [31:0] rd_word,
                     input logic exp_bus, input logic [31:0] exp_baddr,
                     input logic [3:0] exp_be, input logic [31:0] exp_bwd,
                     input logic [31:0] exp_rd, input logic exp_mis,
                     input logic exp_fault, input int exp_resp_n);
    exp_t e, got;
    logic saw_bus, done;
    e.rd = exp_rd; e.mis = exp_mis; e.fault = exp_fault; e.resp_n = exp_resp_n;
    saw_bus = 1'b0;
    done    = 1'b0;
    @(negedge clk);
    check({tag, " req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wd = wd; req_unit = unit;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      if (bus_if.bus_req && !saw_bus) begin
        saw_bus = 1'b1;
        check({tag, " bus_addr"}, bus_if.bus_addr, exp_baddr);
        check({tag, " bus_be"}, bus_if.bus_be, exp_be);
        check({tag, " bus_wd"}, bus_if.bus_wd, exp_bwd);
        check({tag, " bus_we"}, bus_if.bus_we, we);
      end
      if (resp_valid) begin
        done = 1'b1;
        seen_mtcmp_next  = mtimecmp_next;
        seen_mcycle_next = mcycle_next_mem;
        seen_mcycle_we   = mcycle_we;
        if (sb.size() == 0) begin
          check({tag, " scoreboard empty"}, 1'b1, 1'b0);
        end else begin
          got = sb.pop_front();
          check({tag, " resp_rd"}, resp_rd, got.rd);
          check({tag, " resp_misaligned"}, resp_misaligned, got.mis);
          check({tag, " resp_access_fault"}, resp_access_fault, got.fault);
          check({tag, " resp latency"}, 64'(n), 64'(got.resp_n));
          check({tag, " bus_req in resp"}, bus_if.bus_req, 1'b0);
        end
      end else if (bus_if.bus_req && ack_delay >= 0 && n == ack_delay + 1) begin
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rd  = rd_word;
      end
    end
    if (!done) check({tag, " resp_valid within budget"}, 1'b0, 1'b1);
    check({tag, " bus used"}, saw_bus, exp_bus);
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check({tag, " resp one cycle"}, resp_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic quiet;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wd = '0; req_unit = 2'b00;
    bus_if.bus_ack = 1'b0; bus_if.bus_rd = '0;
    mcycle   = 64'h0000_0005_0000_0007;
    mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset req_ready", req_ready, 1'b1);
    check("reset bus_req", bus_if.bus_req, 1'b0);
    check("reset resp_valid", resp_valid, 1'b0);
    check("reset resp_rd", resp_rd, 32'h0);
    check("reset faults", {resp_misaligned, resp_access_fault}, 2'b00);
    check("reset mcycle_we", mcycle_we, 1'b0);
    check("reset mtimecmp_next", mtimecmp_next, mtimecmp);

    txn("sb_byte3", 1'b1, 32'h8000_0003, 32'h0000_00AB, 2'b00, 2, 32'h0,
        1'b1, 32'h8000_0000, 4'b1000, 32'hAB00_0000, 32'h0, 1'b0, 1'b0, 4);
    txn("lh_addr2", 1'b0, 32'h8000_0002, 32'h0, 2'b01, 0, 32'h1234_5678,
        1'b1, 32'h8000_0000, 4'b1100, 32'h0, 32'h0000_1234, 1'b0, 1'b0, 2);
    txn("lw_misal", 1'b0, 32'h8000_0001, 32'h0, 2'b10, 0, 32'h0,
        1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    txn("lh_misal", 1'b0, 32'h8000_0001, 32'h0, 2'b01, 0, 32'h0,
        1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    txn("unit_ill", 1'b0, 32'h8000_0000, 32'h0, 2'b11, 0, 32'h0,
        1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    txn("lb_addr1", 1'b0, 32'h8000_0001, 32'h0, 2'b00, 1, 32'hA1B2_C3D4,
        1'b1, 32'h8000_0000, 4'b0010, 32'h0, 32'h00A1_B2C3, 1'b0, 1'b0, 3);
    txn("sh_addr2", 1'b1, 32'h1000_0002, 32'h0000_BEEF, 2'b01, 0, 32'h0,
        1'b1, 32'h1000_0000, 4'b1100, 32'hBEEF_0000, 32'h0, 1'b0, 1'b0, 2);
    txn("sw_addr0", 1'b1, 32'h1000_0000, 32'h1122_3344, 2'b10, 0, 32'h0,
        1'b1, 32'h1000_0000, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, 1'b0, 2);

    txn("timeout", 1'b0, 32'h9000_0000, 32'h0, 2'b10, -1, 32'h0,
        1'b1, 32'h9000_0000, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 5);
    quiet = 1'b1;
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rd  = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || bus_if.bus_req || !req_ready) quiet = 1'b0;
    end
    bus_if.bus_ack = 1'b0;
    check("late ack ignored", quiet, 1'b1);

    txn("ack_vs_timeout", 1'b0, 32'h9000_0004, 32'h0, 2'b10, 3, 32'h5555_AAAA,
        1'b1, 32'h9000_0004, 4'b1111, 32'h0, 32'h5555_AAAA, 1'b0, 1'b0, 5);

    // Reset while the access waits for the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010; req_unit = 2'b10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("pre-reset bus_req", bus_if.bus_req, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset mid-wait bus_req", bus_if.bus_req, 1'b0);
    check("reset mid-wait idle", req_ready, 1'b1);
    check("reset mid-wait resp_valid", resp_valid, 1'b0);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || bus_if.bus_req) quiet = 1'b0;
    end
    check("no resp after reset", quiet, 1'b1);

    txn("post_reset_lw", 1'b0, 32'h8000_0010, 32'h0, 2'b10, 0, 32'h0BAD_F00D,
        1'b1, 32'h8000_0010, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, 2);

`ifdef MMIO_TIMER_EN
    txn("mmio_sw_mtcmp_hi", 1'b1, 32'h0200_4004, 32'hDEAD_BEEF, 2'b10, 0, 32'h0,
        1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    check("mtimecmp_next in resp", seen_mtcmp_next, 64'hDEAD_BEEF_FFFF_FFFF);
    check("mtimecmp write no mcycle_we", seen_mcycle_we, 1'b0);
    check("mtimecmp_next after resp", mtimecmp_next, 64'hFFFF_FFFF_FFFF_FFFF);
    txn("mmio_lw_mcycle_hi", 1'b0, 32'h0200_BFFC, 32'h0, 2'b10, 0, 32'h0,
        1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_0005, 1'b0, 1'b0, 1);
    txn("mmio_sw_mcycle_lo", 1'b1, 32'h0200_BFF8, 32'h1234_5678, 2'b10, 0, 32'h0,
        1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    check("mcycle_we pulse", seen_mcycle_we, 1'b1);
    check("mcycle_next_mem", seen_mcycle_next, 64'h0000_0005_1234_5678);
    check("mcycle_we after resp", mcycle_we, 1'b0);
    txn("mmio_sh_fault", 1'b1, 32'h0200_4000, 32'h0000_1111, 2'b01, 0, 32'h0,
        1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1);
`else
    txn("plain_sw_timer_addr", 1'b1, 32'h0200_4004, 32'hDEAD_BEEF, 2'b10, 0, 32'h0,
        1'b1, 32'h0200_4004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 2);
    check("mtimecmp_next unchanged", seen_mtcmp_next, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mcycle_we stays low", seen_mcycle_we, 1'b0);
`endif

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
